// File: rtl/pulse_train_gen.sv
// Pulse-train stimulus source for the NOR delay chain under evaluation.
// Emits npulse pulses of H=max(high_cyc,1) active cycles followed by
// L=max(low_cyc,1) quiescent cycles. Configuration is captured when a train
// starts, so the inputs may change freely while the train runs.
module pulse_train_gen #(
    parameter int CNT_W = 16,
    parameter int NP_W  = 8
) (
    input  logic             myclk,
    input  logic             myrst,
    input  logic             start,
    input  logic             abort,
    input  logic             idle_lvl,
    input  logic [CNT_W-1:0] high_cyc,
    input  logic [CNT_W-1:0] low_cyc,
    input  logic [NP_W-1:0]  npulse,
    output logic             myout,
    output logic             busy,
    output logic             done,
    output logic [NP_W-1:0]  pcount
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ACT  = 2'b01,
        QUI  = 2'b10
    } state_t;

    // Load value for a down-counter that must last max(len,1) cycles:
    // the counter expires when it reads zero, so load len-1 (0 for len=0).
    // Counting down from len-1 never wraps, so the all-ones length is exact.
    function automatic logic [CNT_W-1:0] phase_load(input logic [CNT_W-1:0] len);
        if (len == {CNT_W{1'b0}}) begin
            phase_load = {CNT_W{1'b0}};
        end else begin
            phase_load = len - CNT_W'(1'b1);
        end
    endfunction

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic              idle_lat, idle_lat_nx;
    logic [CNT_W-1:0]  high_lat, high_lat_nx;
    logic [CNT_W-1:0]  low_lat, low_lat_nx;
    logic [NP_W-1:0]   np_lat, np_lat_nx;
    logic              myout_nx, busy_nx, done_nx;
    logic [NP_W-1:0]   pcount_nx;
    logic [NP_W:0]     pc_inc;

    // Next-state and next-output logic; every register's next value defaults to hold.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        idle_lat_nx = idle_lat;
        high_lat_nx = high_lat;
        low_lat_nx  = low_lat;
        np_lat_nx   = np_lat;
        myout_nx    = myout;
        busy_nx     = busy;
        done_nx     = 1'b0;
        pcount_nx   = pcount;
        pc_inc      = {1'b0, pcount} + (NP_W+1)'(1'b1);

        case (state)
            IDLE: begin
                myout_nx = idle_lvl;
                if (busy) begin
                    // A zero-pulse train accepted last edge completes here.
                    busy_nx = 1'b0;
                    done_nx = 1'b1;
                end else if (start) begin
                    idle_lat_nx = idle_lvl;
                    high_lat_nx = high_cyc;
                    low_lat_nx  = low_cyc;
                    np_lat_nx   = npulse;
                    pcount_nx   = {NP_W{1'b0}};
                    busy_nx     = 1'b1;
                    if (npulse != {NP_W{1'b0}}) begin
                        state_nx = ACT;
                        myout_nx = ~idle_lvl;
                        cnt_nx   = phase_load(high_cyc);
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    state_nx = IDLE;
                end
            end

            ACT: begin
                if (abort) begin
                    state_nx = IDLE;
                    myout_nx = idle_lat;
                    busy_nx  = 1'b0;
                    cnt_nx   = {CNT_W{1'b0}};
                end else if (cnt == {CNT_W{1'b0}}) begin
                    state_nx = QUI;
                    myout_nx = idle_lat;
                    cnt_nx   = phase_load(low_lat);
                end else begin
                    cnt_nx = cnt - CNT_W'(1'b1);
                end
            end

            QUI: begin
                if (abort) begin
                    state_nx = IDLE;
                    myout_nx = idle_lat;
                    busy_nx  = 1'b0;
                    cnt_nx   = {CNT_W{1'b0}};
                end else if (cnt == {CNT_W{1'b0}}) begin
                    // Count the pulse, saturating at the latched pulse count.
                    if ({1'b0, pcount} < {1'b0, np_lat}) begin
                        pcount_nx = pc_inc[NP_W-1:0];
                    end else begin
                        pcount_nx = pcount;
                    end
                    if (pc_inc < {1'b0, np_lat}) begin
                        state_nx = ACT;
                        myout_nx = ~idle_lat;
                        cnt_nx   = phase_load(high_lat);
                    end else begin
                        state_nx = IDLE;
                        myout_nx = idle_lat;
                        busy_nx  = 1'b0;
                        done_nx  = 1'b1;
                        cnt_nx   = {CNT_W{1'b0}};
                    end
                end else begin
                    cnt_nx = cnt - CNT_W'(1'b1);
                end
            end

            default: begin
                state_nx = IDLE;
                myout_nx = idle_lat;
                busy_nx  = 1'b0;
                cnt_nx   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, counter, latched configuration and output registers.
    always_ff @(posedge myclk or posedge myrst) begin
        if (myrst) begin
            state    <= IDLE;
            cnt      <= {CNT_W{1'b0}};
            idle_lat <= 1'b0;
            high_lat <= {CNT_W{1'b0}};
            low_lat  <= {CNT_W{1'b0}};
            np_lat   <= {NP_W{1'b0}};
            myout    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pcount   <= {NP_W{1'b0}};
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            idle_lat <= idle_lat_nx;
            high_lat <= high_lat_nx;
            low_lat  <= low_lat_nx;
            np_lat   <= np_lat_nx;
            myout    <= myout_nx;
            busy     <= busy_nx;
            done     <= done_nx;
            pcount   <= pcount_nx;
        end
    end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed self-checking bench for pulse_train_gen. Inputs change 1 time unit
// after a rising edge; outputs are sampled at that same point, so "edge i"
// below means the values registered by the i-th edge of a scenario.
module tb_pulse_train_gen;

    logic        myclk;
    logic        myrst;
    logic        start;
    logic        abort;
    logic        idle_lvl;
    logic [15:0] high_cyc;
    logic [15:0] low_cyc;
    logic [7:0]  npulse;
    logic        myout;
    logic        busy;
    logic        done;
    logic [7:0]  pcount;

    int tests;
    int fails;

    pulse_train_gen #(.CNT_W(16), .NP_W(8)) dut (
        .myclk    (myclk),
        .myrst    (myrst),
        .start    (start),
        .abort    (abort),
        .idle_lvl (idle_lvl),
        .high_cyc (high_cyc),
        .low_cyc  (low_cyc),
        .npulse   (npulse),
        .myout    (myout),
        .busy     (busy),
        .done     (done),
        .pcount   (pcount)
    );

    initial begin
        myclk = 1'b0;
        forever #5 myclk = ~myclk;
    end

    task automatic tick();
        @(posedge myclk);
        #1;
    endtask

    task automatic test_reset();
        logic [2:0] exp;
        myrst = 1'b1; start = 1'b0; abort = 1'b0; idle_lvl = 1'b1;
        high_cyc = 16'd0; low_cyc = 16'd0; npulse = 8'd0;
        tick(); tick();
        tests++;
        if ({myout, busy, done, pcount} !== {3'b000, 8'd0}) begin
            fails++;
            $display("FAIL reset_state: got out/busy/done=%b pcount=%0d, expected 000 and 0",
                     {myout, busy, done}, pcount);
        end
        myrst = 1'b0;
        tick();
        exp = 3'b100;
        tests++;
        if ({myout, busy, done} !== exp) begin
            fails++;
            $display("FAIL reset_release_follow: got %b expected %b", {myout, busy, done}, exp);
        end
        idle_lvl = 1'b0;
        #1;
        tests++;
        if (myout !== 1'b1) begin
            fails++;
            $display("FAIL idle_latency_before_edge: got %b expected 1", myout);
        end
        tick();
        tests++;
        if (myout !== 1'b0) begin
            fails++;
            $display("FAIL idle_latency_after_edge: got %b expected 0", myout);
        end
    endtask

    // idle 0, H=3, L=2, 4 pulses: period 5, busy for 20 edges, done at edge 20.
    task automatic test_basic_train();
        logic [2:0] exp;
        idle_lvl = 1'b0; high_cyc = 16'd3; low_cyc = 16'd2; npulse = 8'd4; start = 1'b1;
        for (int i = 0; i < 22; i++) begin
            tick();
            start = 1'b0;
            if (i < 20) exp = {((i % 5) < 3), 1'b1, 1'b0};
            else if (i == 20) exp = 3'b001;
            else exp = 3'b000;
            tests++;
            if ({myout, busy, done} !== exp) begin
                fails++;
                $display("FAIL basic_train edge %0d: got out/busy/done=%b expected %b",
                         i, {myout, busy, done}, exp);
            end
            tests++;
            if (pcount !== ((i < 20) ? 8'(i / 5) : 8'd4)) begin
                fails++;
                $display("FAIL basic_train_pcount edge %0d: got %0d expected %0d",
                         i, pcount, (i < 20) ? (i / 5) : 4);
            end
        end
    endtask

    // H=L=1 from zero lengths, 2 pulses: 1,0,1,0 then done.
    task automatic test_min_phases();
        logic [2:0] exp_tab [0:5];
        exp_tab[0] = 3'b110; exp_tab[1] = 3'b010; exp_tab[2] = 3'b110;
        exp_tab[3] = 3'b010; exp_tab[4] = 3'b001; exp_tab[5] = 3'b000;
        idle_lvl = 1'b0; high_cyc = 16'd0; low_cyc = 16'd0; npulse = 8'd2; start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            start = 1'b0;
            tests++;
            if ({myout, busy, done} !== exp_tab[i]) begin
                fails++;
                $display("FAIL min_phases edge %0d: got %b expected %b",
                         i, {myout, busy, done}, exp_tab[i]);
            end
        end
        tests++;
        if (pcount !== 8'd2) begin
            fails++;
            $display("FAIL min_phases_pcount: got %0d expected 2", pcount);
        end
    endtask

    // Zero-pulse train: busy only at the start edge, done the next edge.
    task automatic test_zero_pulses();
        logic [2:0] exp_tab [0:2];
        exp_tab[0] = 3'b110; exp_tab[1] = 3'b101; exp_tab[2] = 3'b100;
        idle_lvl = 1'b1; high_cyc = 16'd3; low_cyc = 16'd3; npulse = 8'd0; start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            start = 1'b0;
            tests++;
            if ({myout, busy, done} !== exp_tab[i]) begin
                fails++;
                $display("FAIL zero_pulses edge %0d: got %b expected %b",
                         i, {myout, busy, done}, exp_tab[i]);
            end
        end
        tests++;
        if (pcount !== 8'd0) begin
            fails++;
            $display("FAIL zero_pulses_pcount: got %0d expected 0", pcount);
        end
    endtask

    // idle 1, H=L=4, 3 pulses; abort sampled at edge 10 (2nd active cycle of pulse 2).
    task automatic test_abort();
        logic [2:0] exp;
        idle_lvl = 1'b1; high_cyc = 16'd4; low_cyc = 16'd4; npulse = 8'd3; start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            start = 1'b0;
        end
        tests++;
        if ({myout, busy, done, pcount} !== {3'b010, 8'd1}) begin
            fails++;
            $display("FAIL abort_pre: got %b pcount=%0d expected 010 pcount=1",
                     {myout, busy, done}, pcount);
        end
        abort = 1'b1;
        for (int i = 10; i < 13; i++) begin
            tick();
            abort = 1'b0;
            exp = 3'b100;
            tests++;
            if ({myout, busy, done, pcount} !== {exp, 8'd1}) begin
                fails++;
                $display("FAIL abort edge %0d: got %b pcount=%0d expected %b pcount=1",
                         i, {myout, busy, done}, pcount, exp);
            end
        end
    endtask

    // start beats abort in IDLE; abort beats final QUI expiry (no done).
    task automatic test_abort_priority();
        logic [2:0] exp_tab [0:2];
        exp_tab[0] = 3'b110; exp_tab[1] = 3'b110; exp_tab[2] = 3'b010;
        idle_lvl = 1'b0; high_cyc = 16'd2; low_cyc = 16'd1; npulse = 8'd1;
        start = 1'b1; abort = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            start = 1'b0; abort = 1'b0;
            tests++;
            if ({myout, busy, done} !== exp_tab[i]) begin
                fails++;
                $display("FAIL abort_priority edge %0d: got %b expected %b",
                         i, {myout, busy, done}, exp_tab[i]);
            end
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tests++;
        if ({myout, busy, done, pcount} !== {3'b000, 8'd0}) begin
            fails++;
            $display("FAIL abort_over_expiry: got %b pcount=%0d expected 000 pcount=0",
                     {myout, busy, done}, pcount);
        end
    endtask

    // start held high and config changed mid-train; second train at the done edge+1.
    task automatic test_back_to_back();
        logic [2:0] exp;
        idle_lvl = 1'b0; high_cyc = 16'd3; low_cyc = 16'd2; npulse = 8'd2; start = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (i == 0) begin
                high_cyc = 16'd1; low_cyc = 16'd1; npulse = 8'd1;
            end
            if (i == 11) start = 1'b0;
            if (i < 10) exp = {((i % 5) < 3), 1'b1, 1'b0};
            else if (i == 10) exp = 3'b001;
            else if (i == 11) exp = 3'b110;
            else if (i == 12) exp = 3'b010;
            else exp = 3'b001;
            tests++;
            if ({myout, busy, done} !== exp) begin
                fails++;
                $display("FAIL back_to_back edge %0d: got %b expected %b",
                         i, {myout, busy, done}, exp);
            end
        end
        tests++;
        if (pcount !== 8'd1) begin
            fails++;
            $display("FAIL back_to_back_pcount: got %0d expected 1", pcount);
        end
        tick();
        tests++;
        if ({myout, busy, done} !== 3'b000) begin
            fails++;
            $display("FAIL back_to_back_done_once: got %b expected 000", {myout, busy, done});
        end
    endtask

    // Asynchronous reset in pulse 2 ACT: outputs clear before any edge, no done later.
    task automatic test_async_reset();
        idle_lvl = 1'b0; high_cyc = 16'd2; low_cyc = 16'd2; npulse = 8'd3; start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            start = 1'b0;
        end
        tests++;
        if ({myout, busy, done, pcount} !== {3'b110, 8'd1}) begin
            fails++;
            $display("FAIL async_reset_pre: got %b pcount=%0d expected 110 pcount=1",
                     {myout, busy, done}, pcount);
        end
        #2;
        myrst = 1'b1;
        #1;
        tests++;
        if ({myout, busy, done, pcount} !== {3'b000, 8'd0}) begin
            fails++;
            $display("FAIL async_reset_immediate: got %b pcount=%0d expected 000 pcount=0",
                     {myout, busy, done}, pcount);
        end
        idle_lvl = 1'b1;
        tick();
        myrst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if ({myout, busy, done} !== 3'b100) begin
                fails++;
                $display("FAIL async_reset_after %0d: got %b expected 100", i, {myout, busy, done});
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic_train();
        test_min_phases();
        test_zero_pulses();
        test_abort();
        test_abort_priority();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pulse_train_gen.md
PULSE_TRAIN_GEN -- requirements
Module: pulse_train_gen

Interface
REQ-001 The block SHALL be the stimulus source whose output drives the input of the NOR delay chain under evaluation.
REQ-002 The block SHALL have a parameter CNT_W, default 16, giving the width of the phase-length counters.
REQ-003 The block SHALL have a parameter NP_W, default 8, giving the width of the pulse-count counter.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-005 Ports (name, direction, width, meaning):
- myclk  in  1  clock.
- myrst  in  1  asynchronous reset, active-high.
- start  in  1  request one pulse train (sampled in IDLE only).
- abort  in  1  terminate the train in progress.
- idle_lvl  in  1  quiescent level; the active level is ~idle_lvl.
- high_cyc  in  CNT_W  active-phase length in cycles.
- low_cyc  in  CNT_W  quiescent-phase length in cycles.
- npulse  in  NP_W  number of pulses in the train.
- myout  out  1  registered stimulus to the chain input.
- busy  out  1  a train is in progress.
- done  out  1  one-cycle completion strobe.
- pcount  out  NP_W  number of pulses completed in the current or last train.

Function
REQ-006 The state machine SHALL have states IDLE, ACT and QUI; every output SHALL be registered.
REQ-007 In IDLE, myout SHALL take the value idle_lvl had at the previous rising edge (one-cycle latency).
REQ-008 start=1 at edge k in IDLE SHALL latch idle_lvl, high_cyc, low_cyc and npulse, clear pcount, and set busy=1.
- If npulse!=0, it SHALL also enter ACT with myout=~idle_lvl from edge k.
REQ-009 ACT SHALL last exactly H cycles, where H=max(high_cyc,1); the block SHALL then enter QUI with myout=idle_lvl.
REQ-010 QUI SHALL last exactly L cycles, where L=max(low_cyc,1), and pcount SHALL increment at exit from QUI.
- If pcount+1 < npulse, the block SHALL re-enter ACT.
- Otherwise it SHALL enter IDLE with busy=0 and done=1 for exactly one cycle.
REQ-011 For npulse=0, start SHALL produce busy=0, done=1 at edge k+1, pcount=0, and no active level on myout.
REQ-012 Total busy time SHALL be npulse*(H+L) cycles, and done SHALL rise on the edge at which busy falls.
REQ-013 start while busy SHALL be ignored, with no effect on latched configuration or timing.
REQ-014 start during the done cycle SHALL be accepted (the block is in IDLE), with done still pulsing once.
REQ-015 abort=1 in ACT or QUI SHALL, at the next edge, enter IDLE with myout=latched idle_lvl, busy=0 and done=0, and SHALL hold pcount.
REQ-016 abort SHALL take priority over phase expiry at the same edge.
REQ-017 abort in IDLE SHALL be ignored; when start and abort are both high in IDLE, start SHALL win.
REQ-018 Configuration inputs changing while busy SHALL NOT affect the running train.
REQ-019 Phase counters SHALL be CNT_W bits and SHALL count down without wrap, so high_cyc=2^CNT_W-1 yields exactly that many cycles.
REQ-020 pcount SHALL saturate at npulse.

Reset
REQ-021 myrst=1 SHALL immediately (asynchronously) force state=IDLE, myout=0, busy=0, done=0, pcount=0, and clear all counters and latched configuration.
REQ-022 Reset asserted mid-train SHALL abandon the train with no done strobe.
REQ-023 After myrst deasserts, myout SHALL follow idle_lvl per REQ-007 from the first edge.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- idle_lvl=0, high_cyc=3, low_cyc=2, npulse=4, start at edge 10 -> myout 1 on edges 10-12, 0 on 13-14, period 5; busy on edges 10-29; done=1 at edge 30 only; pcount=4.
- high_cyc=0, low_cyc=0, npulse=2 -> myout toggles every cycle (1,0,1,0); busy 4 cycles; done once.
- npulse=0 -> myout stays at idle_lvl; done at edge k+1; busy never asserted beyond edge k.
- idle_lvl=1, high_cyc=4, low_cyc=4, npulse=3; abort on the 2nd cycle of pulse 2 -> myout returns to 1 the next edge; busy=0; done never asserted; pcount=1.
- start pulsed repeatedly during a train and high_cyc changed mid-train -> timing identical to the undisturbed train; start held high through the done cycle -> a second train begins at that edge.
- myrst asserted asynchronously mid-ACT -> myout=0, busy=0, pcount=0 without waiting for a clock edge; no done strobe.
